wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: pipeline result always owns the register-file port; unit results
// go direct when the port is free or wait in a FIFO. Define WB_RR_EN for round-robin unit grant.
module wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int NSRC  = 4,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        Rst_n,
    input  logic                        hold,
    input  logic                        p_valid,
    input  logic [4:0]                  p_rd,
    input  logic [XLEN-1:0]             p_data,
    input  logic [NSRC-2:0]             u_valid,
    output logic [NSRC-2:0]             u_ready,
    input  logic [5*(NSRC-1)-1:0]       u_rd,
    input  logic [XLEN*(NSRC-1)-1:0]    u_data,
    output logic                        rf_we,
    output logic [4:0]                  rf_rd,
    output logic [XLEN-1:0]             rf_data,
    output logic [$clog2(DEPTH):0]      q_count,
    output logic                        q_full
);
    localparam int NU = NSRC - 1;
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(NSRC);

    logic [4:0]      q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic [AW:0]     wptr, rptr;
    logic            q_empty;

    logic [GW-1:0]   g_idx;
    logic            g_any;
    logic [4:0]      g_rd;
    logic [XLEN-1:0] g_dat;
    logic            p_take, head_take, acc, g_keep, do_direct, do_enq;

    assign q_empty = (wptr == rptr);
    assign q_full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign q_count = wptr - rptr;

`ifdef WB_RR_EN
    logic [GW-1:0] rr_ptr;

    // Search units cyclically starting at rr_ptr (unit numbers run 1..NU).
    always_comb begin
        int u;
        g_any = 1'b0;
        g_idx = '0;
        u     = 0;
        for (int k = 0; k < NU; k++) begin
            u = (int'(rr_ptr) - 1 + k) % NU + 1;
            if (!g_any && u_valid[u-1]) begin
                g_any = 1'b1;
                g_idx = GW'(u);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!Rst_n)
            rr_ptr <= GW'(1);
        else if (acc)
            rr_ptr <= (g_idx == GW'(NU)) ? GW'(1) : g_idx + 1'b1;
    end
`else
    always_comb begin
        g_any = 1'b0;
        g_idx = '0;
        for (int u = NU; u >= 1; u--) begin
            if (u_valid[u-1]) begin
                g_any = 1'b1;
                g_idx = GW'(u);
            end
        end
    end
`endif

    always_comb begin
        g_rd  = '0;
        g_dat = '0;
        for (int u = 0; u < NU; u++) begin
            if (g_idx == GW'(u + 1)) begin
                g_rd  = u_rd[u*5 +: 5];
                g_dat = u_data[u*XLEN +: XLEN];
            end
        end
    end

    assign p_take    = p_valid && (p_rd != 5'd0);
    assign head_take = !p_take && !q_empty;

    // Handshake: a unit result transfers on u_valid[i] && u_ready[i]; only the granted unit
    // sees ready. rd==0 is always taken and discarded; otherwise a busy pipeline needs FIFO room
    // (an idle pipeline means either direct write or a head pop frees a slot).
    assign acc       = !hold && g_any && ((g_rd == 5'd0) || !p_take || !q_full);
    assign g_keep    = acc && (g_rd != 5'd0);
    assign do_direct = g_keep && !p_take && q_empty;
    assign do_enq    = g_keep && (p_take ? (g_rd != p_rd) : !q_empty);

    always_comb begin
        u_ready = '0;
        for (int u = 0; u < NU; u++)
            if (acc && g_idx == GW'(u + 1))
                u_ready[u] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            q_vld   <= '0;
            rf_we   <= 1'b0;
            rf_rd   <= '0;
            rf_data <= '0;
        end else if (hold) begin
            rf_we <= 1'b0;
        end else begin
            if (p_take) begin
                rf_we   <= 1'b1;
                rf_rd   <= p_rd;
                rf_data <= p_data;
                for (int i = 0; i < DEPTH; i++)
                    if (q_rd[i] == p_rd)
                        q_vld[i] <= 1'b0;
            end else if (head_take) begin
                // A killed head still consumes this slot, just without a write.
                rf_we <= q_vld[rptr[AW-1:0]];
                if (q_vld[rptr[AW-1:0]]) begin
                    rf_rd   <= q_rd[rptr[AW-1:0]];
                    rf_data <= q_data[rptr[AW-1:0]];
                end
                rptr <= rptr + 1'b1;
            end else if (do_direct) begin
                rf_we   <= 1'b1;
                rf_rd   <= g_rd;
                rf_data <= g_dat;
            end else begin
                rf_we <= 1'b0;
            end
            if (do_enq) begin
                q_rd[wptr[AW-1:0]]   <= g_rd;
                q_data[wptr[AW-1:0]] <= g_dat;
                q_vld[wptr[AW-1:0]]  <= 1'b1;
                wptr                 <= wptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios then random traffic, all checked against a
// queue-based model of the writeback rules (follows WB_RR_EN like the design).
module tb_wb_arbiter;
    localparam int XLEN  = 32;
    localparam int NSRC  = 4;
    localparam int DEPTH = 4;
    localparam int NU    = NSRC - 1;

    logic                     clk = 1'b0;
    logic                     rst_n, hold, p_valid;
    logic [4:0]               p_rd;
    logic [XLEN-1:0]          p_data;
    logic [NU-1:0]            u_valid, u_ready;
    logic [5*NU-1:0]          u_rd;
    logic [XLEN*NU-1:0]       u_data;
    logic                     rf_we;
    logic [4:0]               rf_rd;
    logic [XLEN-1:0]          rf_data;
    logic [$clog2(DEPTH):0]   q_count;
    logic                     q_full;

    wb_arbiter #(.XLEN(XLEN), .NSRC(NSRC), .DEPTH(DEPTH)) dut (
        .clk(clk), .Rst_n(rst_n), .hold(hold),
        .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data),
        .u_valid(u_valid), .u_ready(u_ready), .u_rd(u_rd), .u_data(u_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
        .q_count(q_count), .q_full(q_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic            live;
    } ent_t;

    ent_t            mq[$];
    int              mptr = 1;
    logic            exp_we;
    logic [4:0]      exp_rd;
    logic [XLEN-1:0] exp_data;
    logic            exp_hold;
    logic [NU-1:0]   last_acc;
    int              n_total = 0;
    int              n_pass  = 0;
    int              n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
`ifdef WB_RR_EN
        for (int k = 0; k < NU; k++) begin
            int u;
            u = (mptr - 1 + k) % NU + 1;
            if (u_valid[u-1]) return u;
        end
`else
        for (int u = 1; u <= NU; u++)
            if (u_valid[u-1]) return u;
`endif
        return 0;
    endfunction

    function automatic logic [NU-1:0] model_ready();
        int g;
        logic [4:0] r;
        logic [NU-1:0] v;
        v = '0;
        if (hold) return v;
        g = model_grant();
        if (g == 0) return v;
        r = u_rd[(g-1)*5 +: 5];
        if (r == 5'd0 || !(p_valid && p_rd != 5'd0) || mq.size() < DEPTH)
            v[g-1] = 1'b1;
        return v;
    endfunction

    task automatic model_clock();
        int g;
        logic [4:0] r;
        logic [XLEN-1:0] d;
        logic acc;
        ent_t e;
        last_acc = '0;
        exp_we   = 1'b0;
        exp_hold = 1'b0;
        if (!rst_n) begin
            mq.delete();
            mptr     = 1;
            exp_rd   = '0;
            exp_data = '0;
            return;
        end
        if (hold) begin
            exp_hold = 1'b1;
            return;
        end
        last_acc = model_ready();
        acc = (last_acc != '0);
        g   = model_grant();
        r   = '0;
        d   = '0;
        if (acc) begin
            r    = u_rd[(g-1)*5 +: 5];
            d    = u_data[(g-1)*XLEN +: XLEN];
            mptr = (g == NU) ? 1 : g + 1;
        end
        if (p_valid && p_rd != 5'd0) begin
            exp_we = 1'b1; exp_rd = p_rd; exp_data = p_data;
            foreach (mq[i]) if (mq[i].rd == p_rd) mq[i].live = 1'b0;
            if (acc && r != 5'd0 && r != p_rd) mq.push_back('{r, d, 1'b1});
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            exp_we = e.live;
            if (e.live) begin exp_rd = e.rd; exp_data = e.data; end
            if (acc && r != 5'd0) mq.push_back('{r, d, 1'b1});
        end else if (acc && r != 5'd0) begin
            exp_we = 1'b1; exp_rd = r; exp_data = d;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (rst_n) check("u_ready", u_ready, model_ready());
        @(posedge clk);
        model_clock();
        #1;
        check("rf_we", rf_we, exp_we);
        if (exp_we || exp_hold) begin
            check("rf_rd", rf_rd, exp_rd);
            check("rf_data", rf_data, exp_data);
        end
        check("q_count", q_count, mq.size());
        check("q_full", q_full, mq.size() == DEPTH);
    endtask

    task automatic set_unit(input int u, input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
        u_valid[u-1]             = v;
        u_rd[(u-1)*5 +: 5]       = rd;
        u_data[(u-1)*XLEN +: XLEN] = d;
    endtask

    task automatic set_pipe(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] d);
        p_valid = v; p_rd = rd; p_data = d;
    endtask

    initial begin
        int k;
        rst_n = 1'b0; hold = 1'b0;
        set_pipe(1'b0, 5'd0, '0);
        u_valid = '0; u_rd = '0; u_data = '0;

        // reset state
        cycle(); cycle();
        check("reset_rf_we", rf_we, 0);
        check("reset_rf_rd", rf_rd, 0);
        check("reset_rf_data", rf_data, 0);
        check("reset_q_count", q_count, 0);
        rst_n = 1'b1;
        cycle();

        // pipeline only
        set_pipe(1'b1, 5'd5, 32'hDEADBEEF);
        cycle();
        check("pipe_rf_data", rf_data, 32'hDEADBEEF);
        set_pipe(1'b0, 5'd0, '0);
        cycle();

        // collision: pipeline x3 and unit 1 x7
        set_pipe(1'b1, 5'd3, 32'h33);
        set_unit(1, 1'b1, 5'd7, 32'h11);
        cycle();
        check("coll_q_count", q_count, 1);
        set_pipe(1'b0, 5'd0, '0);
        set_unit(1, 1'b0, 5'd0, '0);
        cycle();
        check("coll_rf_rd", rf_rd, 7);
        check("coll_rf_data", rf_data, 32'h11);
        cycle();

        // fill FIFO with pipeline busy, then drain
        k = 0;
        set_unit(1, 1'b1, 5'd12, 32'h100);
        for (int i = 0; i < 6; i++) begin
            set_pipe(1'b1, 5'd10, 32'hA0 + i);
            cycle();
            if (last_acc[0]) begin k++; set_unit(1, 1'b1, 5'd12, 32'h100 + k); end
        end
        check("fill_q_full", q_full, 1);
        set_pipe(1'b0, 5'd0, '0);
        set_unit(1, 1'b0, 5'd0, '0);
        for (int i = 0; i < 5; i++) cycle();

        // kill: queue x9 from unit 2, then pipeline writes x9
        set_pipe(1'b1, 5'd4, 32'h44);
        set_unit(2, 1'b1, 5'd9, 32'h99);
        cycle();
        set_unit(2, 1'b0, 5'd0, '0);
        set_pipe(1'b1, 5'd9, 32'hAA);
        cycle();
        check("kill_rf_data", rf_data, 32'hAA);
        set_pipe(1'b0, 5'd0, '0);
        cycle();
        check("kill_pop_we", rf_we, 0);
        check("kill_pop_count", q_count, 0);
        cycle();

        // arbitration among all three units, pipeline idle
        set_unit(1, 1'b1, 5'd20, 32'h201);
        set_unit(2, 1'b1, 5'd21, 32'h202);
        set_unit(3, 1'b1, 5'd22, 32'h203);
        for (int i = 0; i < 4; i++) cycle();
        u_valid = '0;
        cycle();

        // hold with two queued, then reset mid-drain
        set_pipe(1'b1, 5'd10, 32'h55);
        set_unit(1, 1'b1, 5'd13, 32'h130);
        cycle();
        set_unit(1, 1'b1, 5'd14, 32'h140);
        cycle();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("hold_q_count", q_count, 2);
        hold = 1'b0;
        set_pipe(1'b0, 5'd0, '0);
        u_valid = '0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("post_reset_count", q_count, 0);

        // random traffic with protocol-respecting units
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            hold  = ($urandom_range(0, 9) == 0);
            set_pipe($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
            cycle();
            for (int u = 1; u <= NU; u++) begin
                if (last_acc[u-1]) u_valid[u-1] = 1'b0;
                if (!u_valid[u-1] && $urandom_range(0, 2) == 0)
                    set_unit(u, 1'b1, 5'($urandom_range(0, 7)), $urandom);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
